// File: rtl/turn_scheduler.sv
// Match-level Cat vs Dog turn sequencer: grants aim/throw turns, applies hit damage,
// enforces aim/flight timeouts and declares the winner. Optional macro: TURN_STARTER_ALT_EN.
module turn_scheduler #(
  parameter int unsigned AIM_TIMEOUT = 650000000,
  parameter int unsigned FLIGHT_MAX  = 195000000,
  parameter int unsigned SETTLE_CYC  = 65000000,
  parameter int unsigned HP_INIT     = 5,
  parameter int unsigned HP_W        = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            throw_start,
  input  logic            proj_done,
  input  logic            proj_hit,
  output logic            cat_turn,
  output logic            dog_turn,
  output logic            turn_timeout,
  output logic [HP_W-1:0] cat_hp,
  output logic [HP_W-1:0] dog_hp,
  output logic            game_over,
  output logic            winner,
  output logic [2:0]      state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_AIM    = 3'd1,
    S_FLIGHT = 3'd2,
    S_SETTLE = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  localparam logic [31:0]     AIM_LAST    = 32'(AIM_TIMEOUT - 1);
  localparam logic [31:0]     FLIGHT_LAST = 32'(FLIGHT_MAX - 1);
  localparam logic [31:0]     SETTLE_LAST = 32'(SETTLE_CYC - 1);
  localparam logic [HP_W-1:0] HP_LOAD     = HP_W'(HP_INIT);
  localparam logic [HP_W-1:0] HP_ONE      = HP_W'(1);

  state_t          r_state;
  logic [31:0]     r_cnt;
  logic            r_side;
  logic [HP_W-1:0] r_cat_hp;
  logic [HP_W-1:0] r_dog_hp;
  logic            r_cat_turn;
  logic            r_dog_turn;
  logic            r_timeout;
  logic            r_game_over;
  logic            r_winner;

  logic            w_aim_exp;
  logic            w_flight_exp;
  logic            w_settle_exp;
  logic [HP_W-1:0] w_opp_hp;
  logic [HP_W-1:0] w_opp_hp_dec;
  logic            w_start_side;

  assign w_aim_exp    = (r_cnt == AIM_LAST);
  assign w_flight_exp = (r_cnt == FLIGHT_LAST);
  assign w_settle_exp = (r_cnt == SETTLE_LAST);
  assign w_opp_hp     = r_side ? r_cat_hp : r_dog_hp;
  assign w_opp_hp_dec = (w_opp_hp == '0) ? '0 : (w_opp_hp - HP_ONE);

`ifdef TURN_STARTER_ALT_EN
  // Starting side of the most recent match; flips on each restart from OVER.
  logic r_first_side;
  assign w_start_side = (r_state == S_OVER) ? ~r_first_side : r_first_side;
`else
  assign w_start_side = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_side      <= 1'b0;
      r_cat_hp    <= '0;
      r_dog_hp    <= '0;
      r_cat_turn  <= 1'b0;
      r_dog_turn  <= 1'b0;
      r_timeout   <= 1'b0;
      r_game_over <= 1'b0;
      r_winner    <= 1'b0;
`ifdef TURN_STARTER_ALT_EN
      r_first_side <= 1'b0;
`endif
    end else begin
      r_timeout <= 1'b0;
      r_cnt     <= r_cnt + 32'd1;
      case (r_state)
        S_IDLE, S_OVER: begin
          if (start) begin
            r_state     <= S_AIM;
            r_cnt       <= '0;
            r_cat_hp    <= HP_LOAD;
            r_dog_hp    <= HP_LOAD;
            r_side      <= w_start_side;
            r_cat_turn  <= ~w_start_side;
            r_dog_turn  <= w_start_side;
            r_game_over <= 1'b0;
            r_winner    <= 1'b0;
`ifdef TURN_STARTER_ALT_EN
            r_first_side <= w_start_side;
`endif
          end
        end
        S_AIM: begin
          // A throw in the expiry cycle wins over the timeout.
          if (throw_start) begin
            r_state <= S_FLIGHT;
            r_cnt   <= '0;
          end else if (w_aim_exp) begin
            r_state    <= S_SETTLE;
            r_cnt      <= '0;
            r_timeout  <= 1'b1;
            r_cat_turn <= 1'b0;
            r_dog_turn <= 1'b0;
          end
        end
        S_FLIGHT: begin
          if (proj_done) begin
            r_cnt      <= '0;
            r_cat_turn <= 1'b0;
            r_dog_turn <= 1'b0;
            r_state    <= S_SETTLE;
            if (proj_hit) begin
              if (r_side) r_cat_hp <= w_opp_hp_dec;
              else        r_dog_hp <= w_opp_hp_dec;
              if (w_opp_hp_dec == '0) begin
                r_state     <= S_OVER;
                r_game_over <= 1'b1;
                r_winner    <= r_side;
              end
            end
          end else if (w_flight_exp) begin
            r_state    <= S_SETTLE;
            r_cnt      <= '0;
            r_timeout  <= 1'b1;
            r_cat_turn <= 1'b0;
            r_dog_turn <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (w_settle_exp) begin
            r_state    <= S_AIM;
            r_cnt      <= '0;
            r_side     <= ~r_side;
            r_cat_turn <= r_side;
            r_dog_turn <= ~r_side;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign cat_turn     = r_cat_turn;
  assign dog_turn     = r_dog_turn;
  assign turn_timeout = r_timeout;
  assign cat_hp       = r_cat_hp;
  assign dog_hp       = r_dog_hp;
  assign game_over    = r_game_over;
  assign winner       = r_winner;
  assign state_dbg    = r_state;

endmodule

// File: tb/tb_turn_scheduler.sv
// Scoreboard bench for turn_scheduler: stimulus queues each expected output change with
// its cycle stamp; a negedge monitor pops and compares whenever any output changes.
module tb_turn_scheduler;

  localparam int unsigned HP_W = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            throw_start;
  logic            proj_done;
  logic            proj_hit;
  logic            cat_turn;
  logic            dog_turn;
  logic            turn_timeout;
  logic [HP_W-1:0] cat_hp;
  logic [HP_W-1:0] dog_hp;
  logic            game_over;
  logic            winner;
  logic [2:0]      state_dbg;

  always #5 clk = ~clk;

  turn_scheduler #(
    .AIM_TIMEOUT(20),
    .FLIGHT_MAX (30),
    .SETTLE_CYC (5),
    .HP_INIT    (2),
    .HP_W       (HP_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .throw_start (throw_start),
    .proj_done   (proj_done),
    .proj_hit    (proj_hit),
    .cat_turn    (cat_turn),
    .dog_turn    (dog_turn),
    .turn_timeout(turn_timeout),
    .cat_hp      (cat_hp),
    .dog_hp      (dog_hp),
    .game_over   (game_over),
    .winner      (winner),
    .state_dbg   (state_dbg)
  );

  typedef struct {
    int         cyc;
    logic [13:0] v;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  bit          mon_en = 1'b0;
  bit          mon_first = 1'b1;
  bit          end_req = 1'b0;
  bit          end_ack = 1'b0;
  logic [13:0] prev;
  logic [13:0] obs;

  // {state, cat_turn, dog_turn, timeout, cat_hp, dog_hp, game_over, winner}
  assign obs = {state_dbg, cat_turn, dog_turn, turn_timeout, cat_hp, dog_hp, game_over, winner};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input int st, input int ct, input int dt, input int to,
                      input int chp, input int dhp, input int go, input int win);
    exp_t e;
    e.cyc = c;
    e.v   = {3'(st), 1'(ct), 1'(dt), 1'(to), 3'(chp), 3'(dhp), 1'(go), 1'(win)};
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (cat_turn && dog_turn) begin
        fails++;
        $display("FAIL grant_excl cyc=%0d cat_turn=1 dog_turn=1 required at most one", cyc);
      end
      if (mon_first || obs !== prev) begin
        mon_first = 1'b0;
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change cyc=%0d st/ct/dt/to/chp/dhp/go/win=%0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d required no change",
                   cyc, obs[13:11], obs[10], obs[9], obs[8], obs[7:5], obs[4:2], obs[1], obs[0]);
        end else begin
          e = q.pop_front();
          if (obs !== e.v || cyc != e.cyc) begin
            fails++;
            $display("FAIL event got cyc=%0d st/ct/dt/to/chp/dhp/go/win=%0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d required cyc=%0d %0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d",
                     cyc, obs[13:11], obs[10], obs[9], obs[8], obs[7:5], obs[4:2], obs[1], obs[0],
                     e.cyc, e.v[13:11], e.v[10], e.v[9], e.v[8], e.v[7:5], e.v[4:2], e.v[1], e.v[0]);
          end
        end
      end
      prev = obs;
      if (end_req && !end_ack) begin
        tests++;
        if (q.size() != 0) begin
          fails++;
          $display("FAIL missing_events got %0d outstanding required 0", q.size());
        end
        end_ack = 1'b1;
      end
    end
  end

  initial begin : stim
    int   s2;
    logic ct0;
    logic dt0;
`ifdef TURN_STARTER_ALT_EN
    ct0 = 1'b0; dt0 = 1'b1;
`else
    ct0 = 1'b1; dt0 = 1'b0;
`endif
    rst = 1'b1; start = 1'b0; throw_start = 1'b0; proj_done = 1'b0; proj_hit = 1'b0;
    tick(2);
    rst = 1'b0;
    mon_en = 1'b1;
    push(cyc, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(1);

    // Match start: cat aims first with full HP
    start = 1'b1; push(cyc + 1, 1, 1, 0, 0, 2, 2, 0, 0); tick(1); start = 1'b0;

    // Cat throws, hits 10 cycles later, settle lasts exactly 5 cycles
    throw_start = 1'b1; push(cyc + 1, 2, 1, 0, 0, 2, 2, 0, 0); tick(1); throw_start = 1'b0;
    tick(9);
    proj_done = 1'b1; proj_hit = 1'b1; push(cyc + 1, 3, 0, 0, 0, 2, 1, 0, 0); tick(1);
    proj_done = 1'b0; proj_hit = 1'b0;
    push(cyc + 5, 1, 0, 1, 0, 2, 1, 0, 0); tick(5);

    // Dog idles through AIM: timeout pulse, no damage, cat next
    push(cyc + 20, 3, 0, 0, 1, 2, 1, 0, 0);
    push(cyc + 21, 3, 0, 0, 0, 2, 1, 0, 0);
    push(cyc + 25, 1, 1, 0, 0, 2, 1, 0, 0);
    tick(25);

    // Throw in the final AIM cycle beats the timeout
    tick(19);
    throw_start = 1'b1; push(cyc + 1, 2, 1, 0, 0, 2, 1, 0, 0); tick(1); throw_start = 1'b0;

    // Flight never resolves: timeout, treated as a miss
    push(cyc + 30, 3, 0, 0, 1, 2, 1, 0, 0);
    push(cyc + 31, 3, 0, 0, 0, 2, 1, 0, 0);
    push(cyc + 35, 1, 0, 1, 0, 2, 1, 0, 0);
    tick(35);

    // Dog forfeits again
    push(cyc + 20, 3, 0, 0, 1, 2, 1, 0, 0);
    push(cyc + 21, 3, 0, 0, 0, 2, 1, 0, 0);
    push(cyc + 25, 1, 1, 0, 0, 2, 1, 0, 0);
    tick(25);

    // Cat's second hit lands in the last FLIGHT cycle: no timeout, cat wins
    throw_start = 1'b1; push(cyc + 1, 2, 1, 0, 0, 2, 1, 0, 0); tick(1); throw_start = 1'b0;
    tick(29);
    proj_done = 1'b1; proj_hit = 1'b1; push(cyc + 1, 4, 0, 0, 0, 2, 0, 1, 0); tick(1);
    proj_done = 1'b0; proj_hit = 1'b0;

    // Ignored pulses in OVER
    throw_start = 1'b1; proj_done = 1'b1; proj_hit = 1'b1; tick(2);
    throw_start = 1'b0; proj_done = 1'b0; proj_hit = 1'b0; tick(2);

    // Restart from OVER reloads HP
    start = 1'b1; push(cyc + 1, 1, ct0, dt0, 0, 2, 2, 0, 0); tick(1); start = 1'b0;

    // Ignored start/proj_done in AIM
    start = 1'b1; proj_done = 1'b1; proj_hit = 1'b1; tick(1);
    start = 1'b0; proj_done = 1'b0; proj_hit = 1'b0;
    throw_start = 1'b1; push(cyc + 1, 2, ct0, dt0, 0, 2, 2, 0, 0); tick(1); throw_start = 1'b0;

    // Ignored start/throw_start in FLIGHT, then a miss
    start = 1'b1; throw_start = 1'b1; tick(2); start = 1'b0; throw_start = 1'b0;
    proj_done = 1'b1; proj_hit = 1'b0; push(cyc + 1, 3, 0, 0, 0, 2, 2, 0, 0); tick(1);
    proj_done = 1'b0;
    s2 = cyc;

    // Ignored everything in SETTLE
    start = 1'b1; throw_start = 1'b1; proj_done = 1'b1; proj_hit = 1'b1; tick(1);
    start = 1'b0; throw_start = 1'b0; proj_done = 1'b0; proj_hit = 1'b0;
    push(s2 + 5, 1, dt0, ct0, 0, 2, 2, 0, 0); tick(4);

    // Reset mid-FLIGHT
    throw_start = 1'b1; push(cyc + 1, 2, dt0, ct0, 0, 2, 2, 0, 0); tick(1); throw_start = 1'b0;
    tick(3);
    rst = 1'b1; push(cyc + 1, 0, 0, 0, 0, 0, 0, 0, 0); tick(1); rst = 1'b0;

    // Ignored pulses in IDLE
    throw_start = 1'b1; proj_done = 1'b1; proj_hit = 1'b1; tick(2);
    throw_start = 1'b0; proj_done = 1'b0; proj_hit = 1'b0; tick(3);

    end_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
